lu_issue_ctrl: RTL and testbench
================================

Name: lu_issue_ctrl

Overview:
- Initiator/driver side of the logic-unit interface in the VLIW datapath.
- Accepts logic-op requests from the bundle decoder over a valid/ready handshake, drives registered opcode and operands into the combinational logic unit, samples its result one cycle later, and returns tagged results through a result FIFO with valid/ready back-pressure.
- Sits between the decode/dispatch slot and the writeback arbiter.

Parameters:
- DATA_W, 32, operand/result width (must match the logic unit).
- TAG_W, 5, destination-register tag width carried alongside each op.
- DEPTH, 4, result FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous pipeline flush; drops all in-flight and queued ops.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at a clk edge.
- in_op  in  3  logic opcode (000 AND, 001 XOR, 010 NAND, 011 OR, 100 NOT A, 101 NOR, 110 two's-complement A, 111 XNOR).
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- in_tag  in  TAG_W  destination tag.
- lu_op  out  3  opcode to logic unit.
- lu_a  out  DATA_W  operand A to logic unit.
- lu_b  out  DATA_W  operand B to logic unit.
- lu_c  in  DATA_W  combinational result from logic unit.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DATA_W  result value.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  any op issued or queued.
- issued_cnt  out  16  count of accepted ops.

Behaviour:
- Reset (rst_n=0 at an edge):
  - in_ready=0 during the reset cycle.
  - lu_op=000, lu_a=0, lu_b=0, out_valid=0, out_result=0, out_tag=0, busy=0, issued_cnt=0.
  - FIFO emptied, issue stage invalid.
  - Reset mid-operation discards everything; no result emerges afterwards.
- FSM states:
  - IDLE: no issue-stage op, FIFO empty.
  - RUN: issue stage or FIFO occupied.
  - FLUSH: one cycle entered when flush=1.
  - Transitions: IDLE->RUN on accept. RUN->IDLE when the last entry pops and nothing is accepted or issued. Any state->FLUSH on flush. FLUSH->IDLE unconditionally.
- Issue stage:
  - On accept at edge N, register in_op/in_a/in_b/in_tag. lu_op/lu_a/lu_b equal the accepted values during cycle N..N+1.
  - When the issue stage is empty, lu_* hold 000/0/0 (no toggling).
- Capture: at edge N+1, lu_c and the tag are written into the FIFO and the issue stage is freed (or reloaded if a new accept happens at the same edge).
- Latency: out_valid rises 2 cycles after the accepting edge when the FIFO was empty. Throughput is 1 op/cycle while out_ready=1.
- Credit rule: in_ready = rst_n & ~flush & (fifo_count + issue_valid < DEPTH). A capture can therefore never overflow the FIFO. in_ready does not depend combinationally on in_valid.
- FIFO:
  - First-word-fall-through.
  - out_result/out_tag are valid whenever out_valid=1 and stay stable until popped.
  - Pop on out_valid & out_ready. Simultaneous push and pop at full/empty is legal and keeps count consistent.
  - Pointers wrap modulo DEPTH.
- flush:
  - Wins over simultaneous accept, capture and pop.
  - Next cycle: FIFO empty, issue stage invalid, out_valid=0, lu_* idle values, busy=0.
  - issued_cnt is not cleared.
- issued_cnt increments on every accept and wraps 0xFFFF->0x0000.
- busy = issue_valid | (fifo_count != 0).
- All opcodes are legal. lu_c is assumed fully driven for every opcode.

Decomposition:
- Shared package lu_pkg:
  - Opcode constants (LU_AND..LU_XNOR).
  - DATA_W default.
  - FSM state typedef {IDLE, RUN, FLUSH}.
- One sub-module, lu_result_fifo (parameterised DATA_W+TAG_W wide, DEPTH deep, FWFT, count output). Issue stage and FSM live in the top.

Test Plan:
- Single op, in_a=0x000000DB, in_b=0x000000BC, in_op=000, tag=3 -> out_valid 2 cycles later with out_result=0x00000098, out_tag=3. Also check lu_op=000 / lu_a=0xDB during the issue cycle.
- Back-to-back ops 001, 110, 111 on the same operands, out_ready=1 -> results 0x00000067, 0xFFFFFF25, 0xFFFFFF98 on consecutive cycles, in order, tags preserved.
- out_ready=0 with 6 requests offered -> exactly 4 accepted (in_ready drops after the 4th), no loss. Then raise out_ready -> 4 results drain in order, then the remaining 2 are accepted.
- flush asserted with 1 op in issue and 3 queued, plus a simultaneous in_valid -> nothing accepted. Next cycle out_valid=0, busy=0. The following op returns a correct result. issued_cnt is unchanged by the flush.
- rst_n=0 for 1 cycle mid-stream -> all outputs at reset values next cycle, no stale result ever appears. issued_cnt=0.
- 65537 accepts -> issued_cnt wraps to 0x0001. FIFO pointer wrap is exercised with no ordering error.

Source files
------------

// File: rtl/lu_pkg.sv
// Shared definitions for the logic-unit issue controller: opcodes, default width
// and the controller FSM state type.
package lu_pkg;

    localparam int LU_DATA_W = 32;

    localparam logic [2:0] LU_AND  = 3'b000;
    localparam logic [2:0] LU_XOR  = 3'b001;
    localparam logic [2:0] LU_NAND = 3'b010;
    localparam logic [2:0] LU_OR   = 3'b011;
    localparam logic [2:0] LU_NOTA = 3'b100;
    localparam logic [2:0] LU_NOR  = 3'b101;
    localparam logic [2:0] LU_NEGA = 3'b110;
    localparam logic [2:0] LU_XNOR = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } lu_state_e;

endpackage

// File: rtl/lu_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count and synchronous clear.
// The read port outputs zero while empty so the consumer side never sees stale data.
module lu_result_fifo
    import lu_pkg::*;
#(
    parameter int W     = LU_DATA_W + 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign do_pop  = pop & (count_q != '0);
    assign do_push = push & ((count_q != CW'(DEPTH)) | do_pop);

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;

endmodule

// File: rtl/lu_issue_ctrl.sv
// Issue controller for the combinational logic unit: one registered issue stage
// feeding the unit, result capture one cycle later, and a credit-protected result FIFO.
module lu_issue_ctrl
    import lu_pkg::*;
#(
    parameter int DATA_W = LU_DATA_W,
    parameter int TAG_W  = 5,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [2:0]        lu_op,
    output logic [DATA_W-1:0] lu_a,
    output logic [DATA_W-1:0] lu_b,
    input  logic [DATA_W-1:0] lu_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy,
    output logic [15:0]       issued_cnt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int FW    = DATA_W + TAG_W;

    lu_state_e         state_q, state_d;
    logic              issue_valid_q, issue_valid_d;
    logic [2:0]        issue_op_q, issue_op_d;
    logic [DATA_W-1:0] issue_a_q, issue_a_d;
    logic [DATA_W-1:0] issue_b_q, issue_b_d;
    logic [TAG_W-1:0]  issue_tag_q, issue_tag_d;
    logic [15:0]       issued_cnt_q, issued_cnt_d;

    logic [CNT_W-1:0]  fifo_count;
    logic [FW-1:0]     fifo_rd_data;
    logic              accept, capture, pop;

    // Credit counts the issue-stage op too, so its capture always has a free slot.
    assign in_ready = rst_n & ~flush
                    & ((fifo_count + CNT_W'(issue_valid_q)) < CNT_W'(DEPTH));
    assign accept   = in_valid & in_ready;
    assign capture  = issue_valid_q & ~flush;
    assign out_valid = (fifo_count != '0);
    assign pop      = out_valid & out_ready & ~flush;

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_op_d    = issue_op_q;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        issue_tag_d   = issue_tag_q;
        if (!flush && accept) begin
            issue_valid_d = 1'b1;
            issue_op_d    = in_op;
            issue_a_d     = in_a;
            issue_b_d     = in_b;
            issue_tag_d   = in_tag;
        end else if (flush || issue_valid_q) begin
            // Park the unit inputs at idle values so they do not toggle.
            issue_valid_d = 1'b0;
            issue_op_d    = LU_AND;
            issue_a_d     = '0;
            issue_b_d     = '0;
            issue_tag_d   = '0;
        end
        issued_cnt_d = issued_cnt_q + 16'(accept);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (pop && fifo_count == CNT_W'(1) && !accept && !issue_valid_q)
                         state_d = IDLE;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = FLUSH;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            issue_valid_q <= 1'b0;
            issue_op_q    <= LU_AND;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            issue_tag_q   <= '0;
            issued_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            issue_valid_q <= issue_valid_d;
            issue_op_q    <= issue_op_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
            issue_tag_q   <= issue_tag_d;
            issued_cnt_q  <= issued_cnt_d;
        end
    end

    lu_result_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (capture),
        .push_data ({lu_c, issue_tag_q}),
        .pop       (pop),
        .pop_data  (fifo_rd_data),
        .count     (fifo_count)
    );

    assign lu_op      = issue_op_q;
    assign lu_a       = issue_a_q;
    assign lu_b       = issue_b_q;
    assign out_result = fifo_rd_data[FW-1:TAG_W];
    assign out_tag    = fifo_rd_data[TAG_W-1:0];
    assign busy       = issue_valid_q | out_valid;
    assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_lu_issue_ctrl.sv
// Directed bench for lu_issue_ctrl with a behavioural logic unit closing the loop.
module tb_lu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]  in_op, lu_op;
    logic [31:0] in_a, in_b, lu_a, lu_b, lu_c, out_result;
    logic [4:0]  in_tag, out_tag;
    logic [15:0] issued_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lu_issue_ctrl #(.DATA_W(32), .TAG_W(5), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .lu_op(lu_op), .lu_a(lu_a), .lu_b(lu_b), .lu_c(lu_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .busy(busy), .issued_cnt(issued_cnt)
    );

    always_comb begin
        case (lu_op)
            3'b000:  lu_c = lu_a & lu_b;
            3'b001:  lu_c = lu_a ^ lu_b;
            3'b010:  lu_c = ~(lu_a & lu_b);
            3'b011:  lu_c = lu_a | lu_b;
            3'b100:  lu_c = ~lu_a;
            3'b101:  lu_c = ~(lu_a | lu_b);
            3'b110:  lu_c = -lu_a;
            default: lu_c = ~(lu_a ^ lu_b);
        endcase
    end

    task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] tag);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_op = 3'b111; in_a = 32'hFFFF_FFFF; in_b = 32'h1; in_tag = 5'h1F;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_valid_busy got=%b%b exp=00", out_valid, busy); end
        checks++; if (lu_op !== 3'b000 || lu_a !== 32'h0 || lu_b !== 32'h0) begin failures++; $display("FAIL reset_lu got=%h/%h/%h exp=0/0/0", lu_op, lu_a, lu_b); end
        checks++; if (out_result !== 32'h0 || out_tag !== 5'h0 || issued_cnt !== 16'h0) begin failures++; $display("FAIL reset_out got=%h/%h/%h exp=0/0/0", out_result, out_tag, issued_cnt); end
        in_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single;
        @(posedge clk); #1 out_ready = 1'b0; drive_req(3'b000, 32'hDB, 32'hBC, 5'd3);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if (lu_op !== 3'b000 || lu_a !== 32'hDB || lu_b !== 32'hBC) begin failures++; $display("FAIL single_issue got=%h/%h/%h exp=0/db/bc", lu_op, lu_a, lu_b); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_early got valid=%b busy=%b exp 0/1", out_valid, busy); end
        checks++; if (issued_cnt !== 16'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", issued_cnt); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h98 || out_tag !== 5'd3) begin failures++; $display("FAIL single_result got v=%b r=%h t=%0d exp v=1 r=98 t=3", out_valid, out_result, out_tag); end
        checks++; if (lu_a !== 32'h0 || lu_b !== 32'h0) begin failures++; $display("FAIL single_lu_idle got=%h/%h exp=0/0", lu_a, lu_b); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_drain got v=%b busy=%b exp 0/0", out_valid, busy); end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  ops [3];
        logic [31:0] exp [3];
        ops[0] = 3'b001; ops[1] = 3'b110; ops[2] = 3'b111;
        exp[0] = 32'h0000_0067; exp[1] = 32'hFFFF_FF25; exp[2] = 32'hFFFF_FF98;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c < 3) drive_req(ops[c], 32'hDB, 32'hBC, 5'(10 + c));
            else in_valid = 1'b0;
            @(negedge clk);
            if (c < 3) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready c=%0d got=%b exp=1", c, in_ready); end
            end
            if (c >= 2 && c <= 4) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== exp[c-2] || out_tag !== 5'(8 + c)) begin
                    failures++; $display("FAIL b2b_result c=%0d got v=%b r=%h t=%0d exp v=1 r=%h t=%0d", c, out_valid, out_result, out_tag, exp[c-2], 8 + c);
                end
            end
            if (c == 5) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
            end
        end
        checks++; if (issued_cnt !== 16'd4) begin failures++; $display("FAIL b2b_cnt got=%0d exp=4", issued_cnt); end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp [6];
        int idx = 0, nres = 0;
        for (int i = 0; i < 6; i++) exp[i] = (32'h11 * (i + 1)) | 32'h0F00;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 8) out_ready = 1'b1;
            if (idx < 6) drive_req(3'b011, 32'h11 * (idx + 1), 32'h0F00, 5'(20 + idx));
            else in_valid = 1'b0;
            @(negedge clk);
            if (cyc == 7) begin
                checks++; if (idx !== 4) begin failures++; $display("FAIL bp_accepted got=%0d exp=4", idx); end
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
                checks++; if (out_valid !== 1'b1 || out_result !== exp[0]) begin failures++; $display("FAIL bp_hold got v=%b r=%h exp v=1 r=%h", out_valid, out_result, exp[0]); end
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                checks++;
                if (nres >= 6 || out_result !== exp[nres] || out_tag !== 5'(20 + nres)) begin
                    failures++; $display("FAIL bp_order n=%0d got r=%h t=%0d exp r=%h t=%0d", nres, out_result, out_tag, exp[nres % 6], 20 + nres);
                end
                nres++;
            end
            if (nres >= 6 && idx >= 6) break;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        checks++; if (nres != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", nres); end
        checks++; if (issued_cnt !== 16'd10) begin failures++; $display("FAIL bp_cnt got=%0d exp=10", issued_cnt); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 drive_req(3'b001, 32'h100 + i, 32'h3, 5'(i));
        end
        @(posedge clk); #1;
        flush = 1'b1; drive_req(3'b011, 32'hAAAA, 32'h5555, 5'd9);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL flush_pre got v=%b busy=%b exp 1/1", out_valid, busy); end
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush_post got v=%b busy=%b exp 0/0", out_valid, busy); end
        checks++; if (lu_op !== 3'b000 || lu_a !== 32'h0 || lu_b !== 32'h0) begin failures++; $display("FAIL flush_lu got=%h/%h/%h exp=0/0/0", lu_op, lu_a, lu_b); end
        checks++; if (issued_cnt !== 16'd14) begin failures++; $display("FAIL flush_cnt got=%0d exp=14", issued_cnt); end
        @(posedge clk); #1 drive_req(3'b001, 32'hF0F0, 32'h0FF0, 5'd7); out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_stale got=%b exp=0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_result !== 32'hFF00 || out_tag !== 5'd7) begin failures++; $display("FAIL flush_next got v=%b r=%h t=%0d exp v=1 r=ff00 t=7", out_valid, out_result, out_tag); end
        @(negedge clk);
        checks++; if (issued_cnt !== 16'd15 || busy !== 1'b0) begin failures++; $display("FAIL flush_after got cnt=%0d busy=%b exp 15/0", issued_cnt, busy); end
    endtask

    task automatic test_reset_mid;
        int stale = 0;
        out_ready = 1'b0;
        @(posedge clk); #1 drive_req(3'b111, 32'h1234, 32'h4321, 5'd1);
        @(posedge clk); #1 drive_req(3'b101, 32'h5678, 32'h8765, 5'd2);
        @(posedge clk); #1 rst_n = 1'b0; drive_req(3'b010, 32'h9, 32'h9, 5'd3);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rmid_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1 rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || issued_cnt !== 16'h0) begin failures++; $display("FAIL rmid_state got v=%b busy=%b cnt=%0d exp 0/0/0", out_valid, busy, issued_cnt); end
        checks++; if (lu_op !== 3'b000 || lu_a !== 32'h0 || lu_b !== 32'h0) begin failures++; $display("FAIL rmid_lu got=%h/%h/%h exp=0/0/0", lu_op, lu_a, lu_b); end
        checks++; if (out_result !== 32'h0 || out_tag !== 5'h0) begin failures++; $display("FAIL rmid_out got=%h/%h exp=0/0", out_result, out_tag); end
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++; if (stale != 0) begin failures++; $display("FAIL rmid_stale got=%0d exp=0", stale); end
    endtask

    task automatic test_wrap;
        int sent = 0, rcv = 0, errs = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 66000; cyc++) begin
            @(posedge clk); #1;
            if (sent < 65537) drive_req(3'b000, 32'(sent), 32'hFFFF_FFFF, 5'(sent));
            else in_valid = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (out_valid) begin
                if (out_result !== 32'(rcv) || out_tag !== 5'(rcv)) errs++;
                rcv++;
            end
            if (rcv >= 65537) break;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if (rcv != 65537) begin failures++; $display("FAIL wrap_received got=%0d exp=65537", rcv); end
        checks++; if (errs != 0) begin failures++; $display("FAIL wrap_order got=%0d errors exp=0", errs); end
        checks++; if (issued_cnt !== 16'h0001) begin failures++; $display("FAIL wrap_cnt got=%h exp=0001", issued_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrap_idle got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
